// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - receiver FSM states and width helpers shared by the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // bits needed to hold 0..max_val, never fewer than one
    function automatic int unsigned width_of(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// rtl/uart_rx_buf.sv - receive byte FIFO; drops the incoming byte and flags overrun when full
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid,
    output logic [count_w(DEPTH)-1:0] o_count,
    output logic                      o_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = i_pop && !w_empty;
    // a pop in the same cycle frees the slot, so a full buffer still accepts
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid   = !w_empty;
    assign o_count   = r_count;
    assign o_overrun = i_push && w_full && !w_pop;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with synchroniser, frame FSM and FIFO; UART_RX_PARITY_EN adds a parity bit
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           serial_rxd,
    output logic [DATA_BITS-1:0]           rx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [count_w(FIFO_DEPTH)-1:0] fifo_count,
    output logic                           frame_err,
    output logic                           parity_err,
    output logic                           overrun
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = width_of(CLKS_PER_BIT);
    localparam int BW = width_of(DATA_BITS - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 r_rxd_meta;
    logic                 r_rxd_sync;
    logic                 r_rxd_prev;
    logic [1:0]           r_settle;
    rx_state_e            r_state;
    rx_state_e            w_state_nxt;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_fall;
    logic                 w_tick;
    logic                 w_push;
    logic                 w_frame_err;
    logic                 w_buf_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 r_parity_err;
    logic                 w_parity_err;
`endif

    // edge detection waits until the reset-high synchroniser has flushed in the real line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_settle   <= '0;
        end else begin
            r_rxd_meta <= serial_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
            if (r_settle != 2'b11) r_settle <= r_settle + 1'b1;
        end
    end

    assign w_fall = (r_settle == 2'b11) && r_rxd_prev && !r_rxd_sync;
    assign w_tick = (r_tick_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_fall) w_state_nxt = START;
            START:     if (w_tick) w_state_nxt = r_rxd_sync ? IDLE : DATA;
            DATA:      if (w_tick && r_bit_idx == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                           w_state_nxt = PARITY;
            PARITY:    if (w_tick) w_state_nxt = STOP;
`else
                           w_state_nxt = STOP;
`endif
            STOP:      if (w_tick) w_state_nxt = r_rxd_sync ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (r_rxd_sync) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_err = 1'b0;
`endif
        if (r_state == STOP && w_tick) begin
            if (!r_rxd_sync)  w_frame_err  = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (r_par_bad) w_parity_err = 1'b1;
`endif
            else              w_push       = 1'b1;
        end
    end

    // IDLE keeps the half-bit preload ready so START lands on mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE) r_tick_cnt <= HALF_BIT;
            else if (w_tick)     r_tick_cnt <= FULL_BIT;
            else                 r_tick_cnt <= r_tick_cnt - 1'b1;

            if (r_state == START) begin
                r_bit_idx <= '0;
            end else if (r_state == DATA && w_tick) begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_shift   <= {r_rxd_sync, r_shift[DATA_BITS-1:1]};
            end
`ifdef UART_RX_PARITY_EN
            if (r_state == START)                  r_par_bad <= 1'b0;
            else if (r_state == PARITY && w_tick)  r_par_bad <= ((^r_shift) ^ r_rxd_sync) != PARITY_ODD;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= w_frame_err;
            r_overrun    <= w_buf_overrun;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err;
`endif
        end
    end

    uart_rx_buf #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_data    (r_shift),
        .i_pop     (rx_ready),
        .o_data    (rx_data),
        .o_valid   (rx_valid),
        .o_count   (fifo_count),
        .o_overrun (w_buf_overrun)
    );

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 25_000_000;
    localparam int BAUD   = 115_200;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DEPTH  = 4;
    localparam logic [7:0] MSG [6] = '{8'hA0, 8'h00, 8'hC8, 8'h4C, 8'h02, 8'h06};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_rxd (serial_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    logic [7:0] rx_log [0:63];
    int rx_n = 0;
    int n_fe = 0;
    int n_pe = 0;
    int n_ov = 0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready && rx_n < 64) begin
            rx_log[rx_n] = rx_data;
            rx_n++;
        end
        if (frame_err)  n_fe++;
        if (parity_err) n_pe++;
        if (overrun)    n_ov++;
    end

    logic [7:0] exp_q [$];
    int rd_idx = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        logic [7:0] e;
        while (rd_idx < rx_n) begin
            if (exp_q.size() == 0) begin
                check({tag, " extra"}, {24'h0, rx_log[rd_idx]}, 32'h100);
            end else begin
                e = exp_q.pop_front();
                check({tag, " byte"}, {24'h0, rx_log[rd_idx]}, {24'h0, e});
            end
            rd_idx++;
        end
        check({tag, " pending"}, exp_q.size(), 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic v);
        serial_rxd = v;
        wait_cycles(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b));
        send_bit(1'b1);
    endtask
`endif

    initial begin
        int fe0;
        int ov0;
        int pe0;
        int n0;
        logic [7:0] b;

        rst_n      = 1'b0;
        serial_rxd = 1'b1;
        rx_ready   = 1'b0;
        wait_cycles(5);
        check("reset rx_valid",   rx_valid,   0);
        check("reset fifo_count", fifo_count, 0);
        check("reset rx_data",    rx_data,    0);
        check("reset errors",     {frame_err, parity_err, overrun}, 0);
        rst_n = 1'b1;
        wait_cycles(10);

        // streaming with the consumer always ready
        fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(MSG[i]);
            send_byte(MSG[i], 1'b1);
        end
        wait_cycles(CPB);
        check_log("stream");
        check("stream errors", (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);

        // fill past capacity with the consumer stalled
        rx_ready = 1'b0;
        ov0 = n_ov;
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH) exp_q.push_back(MSG[i]);
            send_byte(MSG[i], 1'b1);
        end
        wait_cycles(CPB);
        check("full fifo_count", fifo_count, DEPTH);
        check("full head",       rx_data,    MSG[0]);
        check("full rx_valid",   rx_valid,   1);
        check("overrun pulses",  n_ov - ov0, 2);
        check("full no pop",     rx_n - rd_idx, 0);
        rx_ready = 1'b1;
        wait_cycles(20);
        rx_ready = 1'b0;
        wait_cycles(2);
        check_log("drain");
        check("drain fifo_count", fifo_count, 0);
        check("drain rx_valid",   rx_valid,   0);

        // stop bit held low
        fe0 = n_fe;
        send_byte(8'h55, 1'b0);
        serial_rxd = 1'b1;
        wait_cycles(CPB);
        check("frame_err pulses",  n_fe - fe0, 1);
        check("frame fifo_count",  fifo_count, 0);
        check("frame no byte",     rx_n - rd_idx, 0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_cycles(CPB);
        check_log("after frame");

        // short low glitch on an idle line
        n0 = rx_n; fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        serial_rxd = 1'b0;
        wait_cycles(20);
        serial_rxd = 1'b1;
        wait_cycles(2 * CPB);
        check("glitch no byte",    rx_n - n0, 0);
        check("glitch fifo_count", fifo_count, 0);
        check("glitch errors",     (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);

        // reset in the middle of a frame with a byte waiting in the FIFO
        rx_ready = 1'b0;
        fe0 = n_fe;
        send_byte(8'hA0, 1'b1);
        wait_cycles(CPB / 2);
        check("pre-reset fifo_count", fifo_count, 1);
        b = MSG[2];
        send_bit(1'b0);
        send_bit(b[0]);
        send_bit(b[1]);
        serial_rxd = b[2];
        wait_cycles(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("mid-reset rx_valid",   rx_valid,   0);
        check("mid-reset fifo_count", fifo_count, 0);
        check("mid-reset rx_data",    rx_data,    0);
        check("mid-reset errors",     {frame_err, parity_err, overrun}, 0);
        wait_cycles(CPB - CPB / 2);
        send_bit(b[3]);
        send_bit(b[4]);
        send_bit(b[5]);
        serial_rxd = b[6];
        wait_cycles(CPB / 2);
        rst_n = 1'b1;
        wait_cycles(CPB - CPB / 2);
        send_bit(b[7]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(1'b1);
        rx_ready = 1'b1;
        exp_q.push_back(8'h4C);
        send_byte(8'h4C, 1'b1);
        wait_cycles(CPB);
        check_log("after reset");
        check("after reset frame_err", n_fe - fe0, 0);

`ifdef UART_RX_PARITY_EN
        pe0 = n_pe; n0 = rx_n;
        send_bad_parity(MSG[0]);
        wait_cycles(CPB);
        check("parity_err pulses", n_pe - pe0, 1);
        check("parity no byte",    rx_n - n0, 0);
        check("parity fifo_count", fifo_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, meaning payload bits per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 2, meaning receive buffer entries.
REQ-005 SHALL have port clk, input, 1, the single clock. Reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port serial_rxd, input, 1, the asynchronous UART line, idle high.
REQ-008 SHALL have port rx_data, output, DATA_BITS, the FIFO head byte.
REQ-009 SHALL have port rx_valid, output, 1, high when the FIFO is non-empty.
REQ-010 SHALL have port rx_ready, input, 1, the consumer accept signal.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, the number of stored entries.
REQ-012 SHALL have ports frame_err, parity_err and overrun, each output, 1, each a one-cycle error pulse.

Function
REQ-013 SHALL pass serial_rxd through a 2-flop synchroniser; all logic SHALL use the synchronised value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-015 SHALL go from IDLE to START on a falling edge of the synchronised line, then load the bit counter with CLKS_PER_BIT/2.
REQ-016 SHALL treat START as a glitch if the line is high at mid-start; the FSM SHALL return to IDLE and no byte SHALL be produced.
REQ-017 SHALL sample DATA bits every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples.
REQ-018 SHALL push the byte into the FIFO when the stop bit is sampled high.
REQ-019 SHALL raise rx_valid on the cycle after the push when the FIFO was empty.
REQ-020 SHALL, when the stop bit is sampled low, pulse frame_err, discard the byte, and enter WAIT_IDLE until the line is high, then go to IDLE.
REQ-021 SHALL pop the FIFO on rx_valid && rx_ready; rx_data SHALL show the next entry on the following cycle.
REQ-022 SHALL, on a push while full with no pop, drop the new byte, keep the FIFO contents, and pulse overrun.
REQ-023 SHALL accept both operations when a push and a pop occur in the same cycle while full; fifo_count SHALL stay unchanged.
REQ-024 SHALL, on a push and pop in the same cycle while empty, push only (no pop, since rx_valid is low).
REQ-025 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-frame, asynchronously set the FSM to IDLE, clear the pointers, and drive fifo_count=0, rx_valid=0, rx_data=0 and all error pulses to 0; the synchroniser flops SHALL reset to 1.
REQ-027 SHALL, after reset release, not start a frame until a new falling edge is seen.

Configuration
REQ-028 SHALL, with UART_RX_PARITY_EN defined, add a parameter PARITY_ODD (default 0) and a PARITY state after DATA; a parity mismatch SHALL pulse parity_err at the stop sample and discard the byte.
REQ-029 SHALL, without UART_RX_PARITY_EN, have no PARITY state and tie parity_err to 0; the frame is 8N1-style (DATA_BITS, 1 stop bit).

Structure
REQ-030 SHALL define the FSM state enum and the width helpers in package uart_pkg.
REQ-031 SHALL place the FIFO in sub-module uart_rx_buf (parameters WIDTH, DEPTH); the FSM and synchroniser SHALL stay in uart_rx_fifo.

Verification (CLK_HZ=25000000, BAUD=115200, CLKS_PER_BIT=217)
REQ-032 SHALL test: send A0 00 C8 4C 02 06 with rx_ready=1 -> six rx_valid handshakes in that order, no error pulses.
REQ-033 SHALL test: FIFO_DEPTH=4, rx_ready=0, send the same six bytes -> fifo_count=4 holding A0 00 C8 4C, overrun pulsed twice; then rx_ready=1 drains exactly those four.
REQ-034 SHALL test: send 55 with a stop bit of 0 -> frame_err pulses once, fifo_count stays 0, and the next byte 3C is received correctly after the line returns high.
REQ-035 SHALL test: a 20-cycle low glitch on an idle line -> no push and no error pulse.
REQ-036 SHALL test: rst_n asserted in the middle of the DATA bits of byte C8 -> all outputs 0 immediately; the following byte 4C is received intact.
REQ-037 SHALL test, with UART_RX_PARITY_EN and even parity: send A0 with a wrong parity bit -> parity_err pulses once and the byte is dropped.
